sync_debounce_edge: RTL and testbench

Input conditioner for asynchronous single-bit signals such as buttons, external strobes and cross-domain flags. It synchronises the input into the clk domain, debounces it, and produces a clean level plus one-cycle rise and fall pulses. It sits directly upstream of the D flip-flop register stages: level_o, rise_o or fall_o drive their d_i.

---
 rtl/sync_debounce_edge.sv | 138 +++++++++++++
 tb/tb_sync_debounce_edge.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_debounce_edge.sv
// Synchroniser + debouncer producing a clean level and one-cycle rise/fall pulses.
// Optional macro GLITCH_CNT_EN adds a saturating 8-bit rejected-glitch counter (glitch_cnt_o).
module sync_debounce_edge #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic       clk,
  input  logic       rst_ni,
  input  logic       async_i,
  input  logic       en_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o
`ifdef GLITCH_CNT_EN
  ,
  output logic [7:0] glitch_cnt_o
`endif
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
  localparam bit            SINGLE   = (DB_CYCLES == 1);

  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    // Disable parks the FSM on the current level; a pending change is dropped silently.
    if (!en_i) begin
      state_d = level_q ? STABLE_HI : STABLE_LO;
      cnt_d   = '0;
    end else begin
      case (state_q)
        STABLE_LO: if (s) begin
          if (SINGLE) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = PEND_HI;
            cnt_d   = CW'(1);
          end
        end
        PEND_HI: begin
          if (!s) begin
            state_d = STABLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_HI;
            level_d = 1'b1;
            rise_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        STABLE_HI: if (!s) begin
          if (SINGLE) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = PEND_LO;
            cnt_d   = CW'(1);
          end
        end
        PEND_LO: begin
          if (s) begin
            state_d = STABLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d = STABLE_LO;
            level_d = 1'b0;
            fall_d  = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef GLITCH_CNT_EN
  logic [7:0] gcnt_q;
  logic       glitch;

  assign glitch = en_i & (((state_q == PEND_HI) & ~s) | ((state_q == PEND_LO) & s));

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni)                       gcnt_q <= '0;
    else if (glitch && gcnt_q != 8'hFF) gcnt_q <= gcnt_q + 8'd1;
  end

  assign glitch_cnt_o = gcnt_q;
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Bench for sync_debounce_edge: directed scenarios plus random stimulus against a run-length model.
module tb_sync_debounce_edge;
  localparam int SYNC = 2;
  localparam int DB   = 4;

  logic clk = 1'b0;
  logic rst_ni, async_i, en_i;
  logic level_o, rise_o, fall_o;
`ifdef GLITCH_CNT_EN
  logic [7:0] glitch_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Model: s is async_i delayed SYNC edges; a level change needs DB consecutive differing samples.
  logic m_hist[$];
  logic m_level, m_rise, m_fall;
  int   m_run, m_gcnt;

  sync_debounce_edge #(.SYNC_STAGES(SYNC), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .rst_ni  (rst_ni),
    .async_i (async_i),
    .en_i    (en_i),
    .level_o (level_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o)
`ifdef GLITCH_CNT_EN
    ,
    .glitch_cnt_o (glitch_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_hist.delete();
    for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
    m_level = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0; m_gcnt = 0;
  endtask

  // Called at a negedge; drives inputs, advances the model over one posedge, returns at next negedge.
  task automatic tick(input logic a, input logic e);
    logic s_seen;
    async_i = a;
    en_i    = e;
    @(posedge clk);
    s_seen = m_hist.pop_front();
    m_hist.push_back(a);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (!e) m_run = 0;
    else if (s_seen != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = s_seen;
        m_rise  = s_seen;
        m_fall  = ~s_seen;
        m_run   = 0;
      end
    end else begin
      if (m_run > 0 && m_gcnt < 255) m_gcnt++;
      m_run = 0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; async_i = 1'b0; en_i = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({level_o, rise_o, fall_o} !== 3'b000) begin
      n_err++; $display("FAIL reset_outputs: got l/r/f=%b need 000", {level_o, rise_o, fall_o});
    end
`ifdef GLITCH_CNT_EN
    n_cmp++;
    if (glitch_cnt_o !== 8'd0) begin
      n_err++; $display("FAIL reset_gcnt: got %0d need 0", glitch_cnt_o);
    end
`endif
    rst_ni = 1'b1;
  endtask

  task automatic test_rise();
    int first_rise = -1;
    int falls = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        n_err++; $display("FAIL rise_seq k=%0d: got l/r/f=%b need %b", k, {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
      if (rise_o === 1'b1 && first_rise < 0) first_rise = k;
      if (fall_o !== 1'b0) falls++;
    end
    n_cmp++;
    if (first_rise != SYNC + DB || falls != 0) begin
      n_err++; $display("FAIL rise_edge: got edge %0d falls %0d need edge %0d falls 0", first_rise, falls, SYNC + DB);
    end
  endtask

  task automatic test_glitch_reject();
    int pulses = 0;
    int lows = 0;
    for (int k = 1; k <= 10; k++) begin
      tick((k <= 3) ? 1'b0 : 1'b1, 1'b1);
      n_cmp++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        n_err++; $display("FAIL glitch_seq k=%0d: got l/r/f=%b need %b", k, {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
      if (rise_o !== 1'b0 || fall_o !== 1'b0) pulses++;
      if (level_o !== 1'b1) lows++;
    end
    n_cmp++;
    if (pulses != 0 || lows != 0) begin
      n_err++; $display("FAIL glitch_hold: got pulses %0d lows %0d need 0 0", pulses, lows);
    end
`ifdef GLITCH_CNT_EN
    n_cmp++;
    if (glitch_cnt_o !== 8'd1) begin
      n_err++; $display("FAIL glitch_cnt_one: got %0d need 1", glitch_cnt_o);
    end
`endif
  endtask

  task automatic test_pulse_pair();
    int rise_at = -1;
    int fall_at = -1;
    int high = 0;
    for (int k = 1; k <= 8; k++) tick(1'b0, 1'b1);
    n_cmp++;
    if (level_o !== 1'b0) begin
      n_err++; $display("FAIL pulse_pre_low: got %b need 0", level_o);
    end
    for (int k = 1; k <= 16; k++) begin
      tick((k <= 4) ? 1'b1 : 1'b0, 1'b1);
      n_cmp++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        n_err++; $display("FAIL pulse_seq k=%0d: got l/r/f=%b need %b", k, {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
      if (rise_o === 1'b1 && rise_at < 0) rise_at = k;
      if (fall_o === 1'b1 && fall_at < 0) fall_at = k - 4;
      if (level_o === 1'b1) high++;
    end
    n_cmp++;
    if (rise_at != 6 || fall_at != 6 || high != 4) begin
      n_err++; $display("FAIL pulse_timing: got rise %0d fall %0d high %0d need 6 6 4", rise_at, fall_at, high);
    end
  endtask

  task automatic test_enable();
    int rise_at = -1;
    int bad = 0;
    for (int k = 1; k <= 4; k++) tick(1'b1, 1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick(1'b1, 1'b0);
      if (rise_o !== 1'b0 || level_o !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++; $display("FAIL en_hold: got %0d bad cycles need 0", bad);
    end
    for (int k = 1; k <= 6; k++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        n_err++; $display("FAIL en_seq k=%0d: got l/r/f=%b need %b", k, {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
      if (rise_o === 1'b1 && rise_at < 0) rise_at = k;
    end
    n_cmp++;
    if (rise_at != DB) begin
      n_err++; $display("FAIL en_rise_edge: got %0d need %0d", rise_at, DB);
    end
`ifdef GLITCH_CNT_EN
    n_cmp++;
    if (glitch_cnt_o !== 8'd1) begin
      n_err++; $display("FAIL en_gcnt: got %0d need 1", glitch_cnt_o);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int rise_at = -1;
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({level_o, rise_o, fall_o} !== 3'b000) begin
      n_err++; $display("FAIL midreset_async: got l/r/f=%b need 000", {level_o, rise_o, fall_o});
    end
    model_reset();
    @(negedge clk);
    rst_ni = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b1, 1'b1);
      n_cmp++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        n_err++; $display("FAIL midreset_seq k=%0d: got l/r/f=%b need %b", k, {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
      if (rise_o === 1'b1 && rise_at < 0) rise_at = k;
    end
    n_cmp++;
    if (rise_at != SYNC + DB) begin
      n_err++; $display("FAIL midreset_rise: got %0d need %0d", rise_at, SYNC + DB);
    end
  endtask

  task automatic test_random();
    logic a = 1'b0;
    int left = 0;
    logic e;
    for (int k = 0; k < 400; k++) begin
      if (left == 0) begin
        a = $urandom_range(0, 1);
        left = $urandom_range(1, 7);
      end
      left--;
      e = ($urandom_range(0, 9) != 0);
      tick(a, e);
      n_cmp++;
      if ({level_o, rise_o, fall_o} !== {m_level, m_rise, m_fall}) begin
        n_err++; $display("FAIL rand_seq k=%0d: got l/r/f=%b need %b", k, {level_o, rise_o, fall_o}, {m_level, m_rise, m_fall});
      end
`ifdef GLITCH_CNT_EN
      n_cmp++;
      if (glitch_cnt_o !== m_gcnt[7:0]) begin
        n_err++; $display("FAIL rand_gcnt k=%0d: got %0d need %0d", k, glitch_cnt_o, m_gcnt);
      end
`endif
    end
  endtask

  task automatic test_saturate();
    logic v;
    int moved = 0;
    v = m_level;
    for (int k = 0; k < 12; k++) tick(v, 1'b1);
    for (int g = 0; g < 300; g++) begin
      tick(~v, 1'b1); tick(~v, 1'b1); tick(v, 1'b1); tick(v, 1'b1);
      if (level_o !== v || rise_o !== 1'b0 || fall_o !== 1'b0) moved++;
    end
    n_cmp++;
    if (moved != 0) begin
      n_err++; $display("FAIL sat_level: got %0d disturbed glitches need 0", moved);
    end
`ifdef GLITCH_CNT_EN
    n_cmp++;
    if (glitch_cnt_o !== 8'd255) begin
      n_err++; $display("FAIL sat_gcnt: got %0d need 255", glitch_cnt_o);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch_reject();
    test_pulse_pair();
    test_enable();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
